vec_mem_seq: RTL
================

# vec_mem_seq

Multi-cycle sequencer for the CVP14 vector load/store instructions (VLD/VST). It moves one 256-bit vector register (16 × 16-bit elements) between the vector register file and the 16-bit memory bus, one element per bus transfer. It owns Addr/RD/WR/dataOut during a transfer and stalls the decode path through `busy` until the transfer completes.

## Interface
- LANES, 16, elements per vector
- DW, 16, element and bus data width
- AW, 16, bus address width

- Clk1  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- start  in  1  request a transfer; sampled only in IDLE
- is_store  in  1  1 = VST (register → memory), 0 = VLD; latched with start
- base_addr  in  AW  address of element 0; latched with start
- stride  in  AW  address increment between elements; latched with start
- vreg_in  in  LANES*DW  store data; element i is bits [DW*i+DW-1 : DW*i]; latched with start
- mem_ready  in  1  memory accepts or returns the current element this cycle
- DataIn  in  DW  read data, valid in any cycle where RD && mem_ready
- Addr  out  AW  element address
- RD  out  1  read strobe
- WR  out  1  write strobe
- dataOut  out  DW  write data
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- vreg_out  out  LANES*DW  load result; written only on load completion

## Operation
- States are IDLE, RUN, and DONE.
- IDLE → RUN:
  - Occurs on start=1.
  - Latches is_store, base_addr, stride and vreg_in.
  - Clears the element counter `idx` and sets the address register to base_addr.
  - Clears the load staging register.
- RUN:
  - Drives Addr with the address register.
  - Drives RD=!is_store_q and WR=is_store_q.
  - For a store, dataOut = latched element idx.
  - Each cycle with mem_ready=1 completes an element:
    - For a load, staging[idx] ← DataIn.
    - Address register ← address + stride, modulo 2^AW (wraps silently).
    - idx ← idx+1.
  - Cycles with mem_ready=0 hold all state and keep the strobes asserted.
- RUN → DONE: on completion of element LANES-1. For a load, vreg_out ← staging with element LANES-1 merged in, on the same edge.
- DONE:
  - Lasts one cycle, with done=1 and RD=WR=0.
  - Always returns to IDLE.
- Outside RUN: RD=WR=0, Addr=0, dataOut=0.
- start is ignored while busy, including in the DONE cycle. There is no queueing.
- Stores never modify vreg_out.
- stride=0 is legal; every element uses base_addr.

## Timing
- Reset values (asynchronous, Reset=0):
  - state=IDLE, idx=0.
  - Addr=0, RD=0, WR=0, dataOut=0.
  - busy=0, done=0, vreg_out=0.
  - All latched operands cleared.
- Reset asserted mid-transfer aborts immediately. No done pulse is produced, vreg_out is cleared, and strobes drop asynchronously.
- Start sampled at edge 0:
  - Element 0 is on the bus in cycle 1.
  - With mem_ready held at 1, element i is on the bus in cycle 1+i.
  - done is high in cycle LANES+1, and vreg_out is valid in that cycle.
- Minimum start-to-start spacing is LANES+2 cycles.
- Each mem_ready=0 cycle adds one cycle of latency.
- busy rises the cycle after start and falls the cycle after done.

## Configuration
- Macro: VSEQ_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in RUN sends the block to IDLE at the next edge.
  - No done pulse is produced, vreg_out is unchanged, and the staging register is discarded.
  - abort has priority over an element completing in the same cycle.
  - abort is ignored in IDLE and DONE.
- Undefined: no `abort` port. A transfer always runs to completion unless Reset is asserted.

## Test plan
- Load, base=0x0100, stride=1, mem_ready=1, DataIn=0xA000+idx → Addr 0x0100..0x010F in cycles 1..16, RD=1, WR=0. done in cycle 17, vreg_out element i = 0xA000+i.
- Store, base=0xFFFE, stride=1, vreg_in element i = 0x1111*i (lower 16 bits) → Addr 0xFFFE, 0xFFFF, 0x0000..0x000D (wrap), WR=1, dataOut matches per cycle, vreg_out unchanged.
- Load with mem_ready=0 in every other cycle, stride=4 → each address held for 2 cycles, done in cycle 33, vreg_out captures only ready-cycle data.
- start pulsed in RUN and in DONE → both ignored. A new start in the first IDLE cycle after done is accepted, and element 0 appears in the next cycle.
- Reset driven low in cycle 8 of a load → RD=0 and Addr=0 immediately, no done pulse, vreg_out=0. After Reset releases, a fresh start works normally.
- VSEQ_ABORT_EN defined: preload vreg_out=0x…5555 via a completed load, then start a second load and assert abort together with mem_ready=1 in cycle 5 → IDLE next cycle, no done, vreg_out still 0x…5555.

Source files
------------

// File: rtl/vec_mem_seq.sv
// vec_mem_seq: VLD/VST sequencer, one 16-bit element per bus transfer.
// Optional abort input when VSEQ_ABORT_EN is defined.
module vec_mem_seq #(
   parameter int LANES = 16,
   parameter int DW    = 16,
   parameter int AW    = 16
) (
   input  logic                Clk1,
   input  logic                Reset,
   input  logic                start,
   input  logic                is_store,
   input  logic [AW-1:0]       base_addr,
   input  logic [AW-1:0]       stride,
   input  logic [LANES*DW-1:0] vreg_in,
   input  logic                mem_ready,
   input  logic [DW-1:0]       DataIn,
`ifdef VSEQ_ABORT_EN
   input  logic                abort,
`endif
   output logic [AW-1:0]       Addr,
   output logic                RD,
   output logic                WR,
   output logic [DW-1:0]       dataOut,
   output logic                busy,
   output logic                done,
   output logic [LANES*DW-1:0] vreg_out
);

   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t              st_q;
   logic [IW-1:0]       idx_q;
   logic                store_q;
   logic [AW-1:0]       addr_q;
   logic [AW-1:0]       stride_q;
   logic [LANES*DW-1:0] data_q;
   logic [LANES*DW-1:0] stage_q;
   logic [LANES*DW-1:0] stage_mrg;
   logic                last;
   logic                abort_w;

`ifdef VSEQ_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign last = (idx_q == IW'(LANES - 1));

   // staging with the element arriving this cycle merged in
   always_comb begin
      stage_mrg = stage_q;
      stage_mrg[idx_q*DW +: DW] = DataIn;
   end

   // sequencer state, operand latches and load result
   always_ff @(posedge Clk1 or negedge Reset) begin
      if (!Reset) begin
         st_q     <= IDLE;
         idx_q    <= '0;
         store_q  <= 1'b0;
         addr_q   <= '0;
         stride_q <= '0;
         data_q   <= '0;
         stage_q  <= '0;
         vreg_out <= '0;
      end else begin
         unique case (st_q)
            IDLE: begin
               if (start) begin
                  st_q     <= RUN;
                  store_q  <= is_store;
                  addr_q   <= base_addr;
                  stride_q <= stride;
                  data_q   <= vreg_in;
                  idx_q    <= '0;
                  stage_q  <= '0;
               end
            end
            RUN: begin
               if (abort_w) begin
                  st_q <= IDLE;
               end else if (mem_ready) begin
                  if (!store_q)
                     stage_q[idx_q*DW +: DW] <= DataIn;
                  addr_q <= addr_q + stride_q;
                  idx_q  <= idx_q + 1'b1;
                  if (last) begin
                     st_q <= DONE;
                     if (!store_q)
                        vreg_out <= stage_mrg;
                  end
               end
            end
            DONE: st_q <= IDLE;
            default: st_q <= IDLE;
         endcase
      end
   end

   // bus outputs are only driven while a transfer is running
   always_comb begin
      Addr    = '0;
      RD      = 1'b0;
      WR      = 1'b0;
      dataOut = '0;
      busy    = (st_q != IDLE);
      done    = (st_q == DONE);
      if (st_q == RUN) begin
         Addr = addr_q;
         RD   = !store_q;
         WR   = store_q;
         if (store_q)
            dataOut = data_q[idx_q*DW +: DW];
      end
   end

endmodule
